// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between instruction fetch and load/store
//   clk, rst (async, active-low)
//   i_req/i_addr -> i_gnt, i_rvalid/i_rdata    : fetch requester
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid/d_rdata : data requester
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata : RAM side
module mem_arbiter #(
   parameter int ADDR_WIDTH     = 9,
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_DATA_BURST = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   localparam logic [3:0] BURST = 4'(MAX_DATA_BURST);
   logic [3:0] r_cnt;
   logic       r_i_rd_pend;
   logic       r_d_rd_pend;
   logic       w_fetch_turn;
   // fetch overrides data priority once it has lost MAX_DATA_BURST times in a row
   assign w_fetch_turn = i_req & (r_cnt >= BURST);
   assign d_gnt        = rst & d_req & ~w_fetch_turn;
   assign i_gnt        = rst & i_req & ~(d_req & ~w_fetch_turn);
   assign mem_en       = i_gnt | d_gnt;
   assign mem_we       = d_gnt & d_we;
   assign mem_addr     = i_gnt ? i_addr : d_addr;
   assign mem_wdata    = d_wdata;
   assign i_rvalid     = r_i_rd_pend;
   assign d_rvalid     = r_d_rd_pend;
   assign i_rdata      = mem_rdata;
   assign d_rdata      = mem_rdata;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt       <= '0;
         r_i_rd_pend <= 1'b0;
         r_d_rd_pend <= 1'b0;
      end else begin
         r_cnt       <= (d_gnt & i_req) ? ((r_cnt >= BURST) ? BURST : r_cnt + 4'd1) :
                        (i_gnt | ~i_req) ? 4'd0 : r_cnt;
         r_i_rd_pend <= i_gnt;
         r_d_rd_pend <= d_gnt & ~d_we;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed bench for mem_arbiter against a behavioural model
module tb_mem_arbiter;
   localparam int AW = 9;
   localparam int DW = 32;
   localparam int MAXB = 4;
   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic          i_gnt, i_rvalid;
   logic [DW-1:0] i_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_gnt, d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   int checks = 0;
   int failures = 0;
   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_BURST(MAXB)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );
   always #5 clk = ~clk;
   function automatic logic [DW-1:0] init_word(int a);
      return (a < 4) ? 32'h20080005 + 32'(a) : 32'(a) * 32'h9E3779B9;
   endfunction
   // RAM the arbiter drives; reloads its image while reset is held
   logic [DW-1:0] ram [512];
   always @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 512; k++) ram[k] <= init_word(k);
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else mem_rdata <= ram[mem_addr];
      end
   end
   // reference model: who wins, what each read should return, how often fetch has lost
   logic [DW-1:0] ref_mem [512];
   int            m_losses = 0;
   bit            m_i_pend = 0;
   bit            m_d_pend = 0;
   logic [DW-1:0] m_i_data = '0;
   logic [DW-1:0] m_d_data = '0;
   // 0 none, 1 fetch, 2 data
   function automatic int model_grant();
      if (!rst) return 0;
      if (i_req && d_req) return (m_losses >= MAXB) ? 1 : 2;
      return i_req ? 1 : (d_req ? 2 : 0);
   endfunction
   always @(posedge clk or negedge rst) begin : mdl
      int g;
      if (!rst) begin
         m_losses = 0;
         m_i_pend = 0;
         m_d_pend = 0;
         for (int k = 0; k < 512; k++) ref_mem[k] = init_word(k);
      end else begin
         g = model_grant();
         m_i_pend = (g == 1);
         m_d_pend = (g == 2) && !d_we;
         if (g == 1) m_i_data = ref_mem[i_addr];
         if (g == 2 && d_we) ref_mem[d_addr] = d_wdata;
         if (g == 2 && !d_we) m_d_data = ref_mem[d_addr];
         if (!i_req || g == 1) m_losses = 0;
         else if (g == 2 && m_losses < MAXB) m_losses = m_losses + 1;
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      i_req = 1; d_req = 1; d_we = 1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
         failures++; $display("FAIL reset_gnt: got i=%b d=%b exp 0 0", i_gnt, d_gnt);
      end
      checks++;
      if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
         failures++; $display("FAIL reset_mem: got en=%b we=%b exp 0 0", mem_en, mem_we);
      end
      checks++;
      if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
         failures++; $display("FAIL reset_rvalid: got i=%b d=%b exp 0 0", i_rvalid, d_rvalid);
      end
      i_req = 0; d_req = 0; d_we = 0;
      #2 rst = 1;
      tick();
   endtask
   task automatic test_fetch_only();
      i_req = 1; d_req = 0;
      for (int k = 0; k < 4; k++) begin
         i_addr = 9'(k);
         #1;
         checks++;
         if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== 9'(k) || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL fetch_gnt[%0d]: got i=%b d=%b addr=%h we=%b exp 1 0 %h 0", k, i_gnt, d_gnt, mem_addr, mem_we, k);
         end
         tick();
         checks++;
         if (i_rvalid !== 1'b1 || i_rdata !== 32'h20080005 + 32'(k)) begin
            failures++;
            $display("FAIL fetch_data[%0d]: got v=%b %h exp 1 %h", k, i_rvalid, i_rdata, 32'h20080005 + 32'(k));
         end
      end
      i_req = 0;
      tick();
   endtask
   task automatic test_write_read();
      d_req = 1; d_we = 1; d_addr = 9'h1F0; d_wdata = 32'hDEADBEEF;
      #1;
      checks++;
      if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 9'h1F0 || mem_wdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL wr_gnt: got g=%b we=%b a=%h wd=%h exp 1 1 1f0 deadbeef", d_gnt, mem_we, mem_addr, mem_wdata);
      end
      tick();
      checks++;
      if (d_rvalid !== 1'b0) begin
         failures++; $display("FAIL wr_no_rvalid: got %b exp 0", d_rvalid);
      end
      d_we = 0; d_wdata = 32'h0;
      #1;
      checks++;
      if (d_gnt !== 1'b1 || mem_we !== 1'b0 || mem_en !== 1'b1) begin
         failures++; $display("FAIL rd_gnt: got g=%b we=%b en=%b exp 1 0 1", d_gnt, mem_we, mem_en);
      end
      tick();
      checks++;
      if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
         failures++; $display("FAIL raw_data: got v=%b %h exp 1 deadbeef", d_rvalid, d_rdata);
      end
      d_req = 0;
      tick();
   endtask
   task automatic test_contention();
      i_req = 1; d_req = 1; d_we = 0;
      i_addr = 9'($urandom_range(0, 511)); d_addr = 9'($urandom_range(0, 511));
      for (int k = 0; k < 10; k++) begin
         #1;
         checks++;
         if (i_gnt === d_gnt || d_gnt !== (k % 5 != 4)) begin
            failures++;
            $display("FAIL contention[%0d]: got i=%b d=%b exp d=%b", k, i_gnt, d_gnt, k % 5 != 4);
         end
         tick();
         checks++;
         if (i_rvalid !== m_i_pend || d_rvalid !== m_d_pend ||
             (m_i_pend && i_rdata !== m_i_data) || (m_d_pend && d_rdata !== m_d_data)) begin
            failures++;
            $display("FAIL contention_rd[%0d]: got iv=%b dv=%b i=%h d=%h exp %b %b %h %h",
                     k, i_rvalid, d_rvalid, i_rdata, d_rdata, m_i_pend, m_d_pend, m_i_data, m_d_data);
         end
      end
      i_req = 0; d_req = 0;
      tick();
   endtask
   task automatic test_fetch_dropout();
      d_req = 1; d_we = 0;
      for (int k = 0; k < 8; k++) begin
         i_req = (k != 2);
         #1;
         checks++;
         if (d_gnt !== (k != 7) || i_gnt !== (k == 7)) begin
            failures++;
            $display("FAIL dropout[%0d]: got i=%b d=%b exp i=%b d=%b", k, i_gnt, d_gnt, k == 7, k != 7);
         end
         tick();
      end
      i_req = 0; d_req = 0;
      tick();
   endtask
   task automatic test_idle();
      i_req = 0; d_req = 0;
      tick();
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
            failures++; $display("FAIL idle_mem[%0d]: got en=%b we=%b exp 0 0", k, mem_en, mem_we);
         end
         tick();
         checks++;
         if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            failures++; $display("FAIL idle_rvalid[%0d]: got i=%b d=%b exp 0 0", k, i_rvalid, d_rvalid);
         end
      end
   endtask
   task automatic test_random();
      bit ig = 1;
      bit dg = 1;
      int g;
      for (int k = 0; k < 300; k++) begin
         if (!i_req || ig) begin
            i_req = ($urandom_range(0, 3) != 0);
            i_addr = 9'($urandom_range(0, 15));
         end else if ($urandom_range(0, 7) == 0) i_req = 0;
         if (!d_req || dg) begin
            d_req = ($urandom_range(0, 3) != 0);
            d_we = $urandom_range(0, 1) == 1;
            d_addr = 9'($urandom_range(0, 15));
            d_wdata = $urandom;
         end else if ($urandom_range(0, 7) == 0) d_req = 0;
         #1;
         g = model_grant();
         ig = (g == 1);
         dg = (g == 2);
         checks++;
         if (i_gnt !== ig || d_gnt !== dg || mem_en !== (g != 0) || mem_we !== (dg && d_we) ||
             (g != 0 && mem_addr !== (ig ? i_addr : d_addr)) || (mem_we && mem_wdata !== d_wdata)) begin
            failures++;
            $display("FAIL rand_gnt[%0d]: got i=%b d=%b en=%b we=%b a=%h exp i=%b d=%b a=%h",
                     k, i_gnt, d_gnt, mem_en, mem_we, mem_addr, ig, dg, ig ? i_addr : d_addr);
         end
         tick();
         checks++;
         if (i_rvalid !== m_i_pend || d_rvalid !== m_d_pend ||
             (m_i_pend && i_rdata !== m_i_data) || (m_d_pend && d_rdata !== m_d_data)) begin
            failures++;
            $display("FAIL rand_rd[%0d]: got iv=%b dv=%b i=%h d=%h exp %b %b %h %h",
                     k, i_rvalid, d_rvalid, i_rdata, d_rdata, m_i_pend, m_d_pend, m_i_data, m_d_data);
         end
      end
      i_req = 0; d_req = 0;
      tick();
   endtask
   task automatic test_async_reset();
      i_req = 1; i_addr = 9'd3; d_req = 0;
      #1;
      checks++;
      if (i_gnt !== 1'b1) begin
         failures++; $display("FAIL ar_pre_gnt: got %b exp 1", i_gnt);
      end
      tick();
      #1 rst = 0;
      #1;
      checks++;
      if (i_rvalid !== 1'b0 || i_gnt !== 1'b0) begin
         failures++; $display("FAIL ar_immediate: got v=%b g=%b exp 0 0", i_rvalid, i_gnt);
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (i_rvalid !== 1'b0) begin
            failures++; $display("FAIL ar_hold[%0d]: got %b exp 0", k, i_rvalid);
         end
      end
      #1 rst = 1;
      #1;
      checks++;
      if (i_gnt !== 1'b1 || mem_addr !== 9'd3) begin
         failures++; $display("FAIL ar_regrant: got g=%b a=%h exp 1 003", i_gnt, mem_addr);
      end
      tick();
      checks++;
      if (i_rvalid !== 1'b1 || i_rdata !== 32'h20080008) begin
         failures++; $display("FAIL ar_rdata: got v=%b %h exp 1 20080008", i_rvalid, i_rdata);
      end
      i_req = 0;
      tick();
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_fetch_only();
      test_write_read();
      test_contention();
      test_fetch_dropout();
      test_idle();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
